ex_hilo_div: RTL and testbench
==============================

Name: ex_hilo_div

Overview:
- EX-stage HI/LO unit. Sits beside the EX ALU.
- Executes mult/multu/div/divu/mthi/mtlo and supplies mfhi/mflo read data into the EX result. That result travels on ex_to_mem_bus to MEM.
- Division is iterative, 1 quotient bit per cycle. The unit raises a stall request to hold IF/ID/EX until the quotient is ready.
- Owns the architectural HI and LO registers.

Parameters:
- DIV_BITS, 32, dividend/divisor width and iteration count.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stall  in  `StallBus  pipeline stall vector. EX advances when stall[3]==`NoStop (ex_advance).
- inst_div  in  1  signed divide in EX
- inst_divu  in  1  unsigned divide in EX
- inst_mult  in  1  signed multiply in EX
- inst_multu  in  1  unsigned multiply in EX
- inst_mthi  in  1  HI <= rs_data
- inst_mtlo  in  1  LO <= rs_data
- inst_mfhi  in  1  select HI as result
- inst_mflo  in  1  select LO as result
- rs_data  in  32  forwarded rs operand (dividend / multiplicand)
- rt_data  in  32  forwarded rt operand (divisor / multiplier)
- hilo_rdata  out  32  HI if inst_mfhi, LO if inst_mflo, else 0. Combinational from registers.
- stall_req  out  1  request to controller to freeze IF/ID/EX
- div_busy  out  1  state==BUSY (debug/perf)

Behaviour:
- Reset:
  - state=IDLE, HI=0, LO=0, count=0.
  - stall_req=0 and div_busy=0 while rst is high, regardless of inputs.
- div_op = inst_div | inst_divu.
- stall_req = div_op & (state != DONE).
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If div_op and rt_data==0, go to DONE. Result: LO=32'hFFFFFFFF, HI=rs_data (defined divide-by-zero result).
  - Else if div_op: latch |rs| and |rt| (inst_div: two's-complement magnitude; divu: raw), latch sign_q = rs[31]^rt[31] and sign_r = rs[31] (both 0 for divu). Clear remainder and count, go to BUSY.
- BUSY, restoring algorithm, one step per cycle:
  - {rem,quo} shifted left by 1.
  - If rem >= divisor: rem -= divisor, quo[0] = 1.
  - count += 1; when count==DIV_BITS-1 on the step just taken, go to DONE.
- DONE:
  - Final LO = sign_q ? -quo : quo; HI = sign_r ? -rem : rem.
  - Stay in DONE until ex_advance.
  - On ex_advance: write HI/LO, go to IDLE.
  - Downstream stall while in DONE keeps the result held; HI/LO are written exactly once.
- Latency: div issued in cycle 0 gives stall_req high in cycles 0..32 (33 cycles), low in cycle 33 (DONE). Write occurs at the end of the first DONE cycle with ex_advance.
- mult/multu:
  - Single-cycle 32x32->64 product; signed for mult.
  - {HI,LO} <= product on ex_advance.
  - No stall.
- mthi/mtlo: write on ex_advance only.
- mfhi/mflo read current HI/LO. A preceding HI/LO writer has already committed at its EX advance, so no bypass is needed.
- Width: MIN_INT / -1 gives LO=32'h80000000, HI=0; wraps naturally.
- Reset mid-division: FSM aborts to IDLE; HI/LO = 0.
- Op inputs deasserted while in BUSY (should not happen, since EX is frozen): return to IDLE next cycle, no HI/LO write.
- At most one op input is high per cycle.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: in IDLE with div_op and nonzero divisor, if |rs| < |rt| (unsigned compare of magnitudes), go directly to DONE with quo=0, rem=|rs|. Sign fix-up is applied as normal. stall_req is high for 1 cycle only.
- Undefined: every nonzero-divisor division takes the full DIV_BITS iterations.

Test Plan:
- div rs=7 rt=2, no external stall -> stall_req high 33 cycles, then LO=3, HI=1 after ex_advance.
- div rs=32'hFFFFFFF9 (-7) rt=2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF; divu rs=32'hFFFFFFFF rt=32'h10 -> LO=32'h0FFFFFFF, HI=32'hF.
- div rt=0 rs=5 -> DONE after 1 cycle, LO=32'hFFFFFFFF, HI=5; then mfhi -> hilo_rdata=5.
- div 100/7 with stall[3]=`Stop held 3 cycles in DONE -> HI/LO unchanged until release, then LO=14, HI=2, written once.
- mult rs=32'hFFFFFFFE rt=3 -> HI=32'hFFFFFFFF, LO=32'hFFFFFFFA; multu same operands -> HI=2, LO=32'hFFFFFFFA; no stall_req.
- rst asserted on BUSY cycle 10 -> next cycle state=IDLE, stall_req=0, HI=LO=0. With DIV_EARLY_OUT_EN defined, div 3/9 -> stall_req 1 cycle, LO=0, HI=3.

Source files
------------

// File: rtl/ex_hilo_div.sv
// EX-stage HI/LO unit: mult/multu, iterative div/divu, mthi/mtlo, mfhi/mflo.
// Optional macro DIV_EARLY_OUT_EN skips iteration when |rs| < |rt|.
`ifndef StallBus
`define StallBus 5:0
`endif
`ifndef NoStop
`define NoStop 1'b0
`endif
`ifndef Stop
`define Stop 1'b1
`endif

module ex_hilo_div #(
    parameter int DIV_BITS = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [`StallBus]    stall,
    input  logic                inst_div,
    input  logic                inst_divu,
    input  logic                inst_mult,
    input  logic                inst_multu,
    input  logic                inst_mthi,
    input  logic                inst_mtlo,
    input  logic                inst_mfhi,
    input  logic                inst_mflo,
    input  logic [DIV_BITS-1:0] rs_data,
    input  logic [DIV_BITS-1:0] rt_data,
    output logic [DIV_BITS-1:0] hilo_rdata,
    output logic                stall_req,
    output logic                div_busy
);

    localparam int W  = DIV_BITS;
    localparam int CW = $clog2(DIV_BITS);
    localparam logic [CW-1:0] LAST = CW'(DIV_BITS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  hi_q, hi_d;
    logic [W-1:0]  lo_q, lo_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sgn_q_q, sgn_q_d;
    logic          sgn_r_q, sgn_r_d;

    logic          ex_advance;
    logic          div_op;
    logic [W-1:0]  mag_rs;
    logic [W-1:0]  mag_rt;
    logic [W:0]    rem_sh;
    logic [W:0]    rem_sub;
    logic [2*W-1:0] prod_s;
    logic [2*W-1:0] prod_u;
    logic          unused_stall;

    assign ex_advance = (stall[3] == `NoStop);
    assign div_op     = inst_div | inst_divu;
    assign unused_stall = ^stall;

    assign mag_rs = (inst_div & rs_data[W-1]) ? -rs_data : rs_data;
    assign mag_rt = (inst_div & rt_data[W-1]) ? -rt_data : rt_data;

    // Sign-extended operands give the correct low 2W bits of the signed product.
    assign prod_s = {{W{rs_data[W-1]}}, rs_data} * {{W{rt_data[W-1]}}, rt_data};
    assign prod_u = {{W{1'b0}}, rs_data} * {{W{1'b0}}, rt_data};

    assign rem_sh  = {rem_q, quo_q[W-1]};
    assign rem_sub = rem_sh - {1'b0, dvs_q};

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        sgn_q_d = sgn_q_q;
        sgn_r_d = sgn_r_q;
        unique case (state_q)
            S_IDLE: begin
                if (div_op) begin
                    if (rt_data == '0) begin
                        quo_d   = '1;
                        rem_d   = rs_data;
                        sgn_q_d = 1'b0;
                        sgn_r_d = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        quo_d   = mag_rs;
                        dvs_d   = mag_rt;
                        rem_d   = '0;
                        cnt_d   = '0;
                        sgn_q_d = inst_div & (rs_data[W-1] ^ rt_data[W-1]);
                        sgn_r_d = inst_div & rs_data[W-1];
                        state_d = S_BUSY;
`ifdef DIV_EARLY_OUT_EN
                        if (mag_rs < mag_rt) begin
                            quo_d   = '0;
                            rem_d   = mag_rs;
                            state_d = S_DONE;
                        end
`endif
                    end
                end else if (ex_advance) begin
                    unique case (1'b1)
                        inst_mult:  {hi_d, lo_d} = prod_s;
                        inst_multu: {hi_d, lo_d} = prod_u;
                        inst_mthi:  hi_d = rs_data;
                        inst_mtlo:  lo_d = rs_data;
                        default: ;
                    endcase
                end
            end
            S_BUSY: begin
                if (!div_op) begin
                    state_d = S_IDLE;
                end else begin
                    // No borrow out of the subtract means rem >= divisor.
                    quo_d = {quo_q[W-2:0], ~rem_sub[W]};
                    rem_d = rem_sub[W] ? rem_sh[W-1:0] : rem_sub[W-1:0];
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST) state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (ex_advance) begin
                    lo_d    = sgn_q_q ? -quo_q : quo_q;
                    hi_d    = sgn_r_q ? -rem_q : rem_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            sgn_q_q <= 1'b0;
            sgn_r_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            sgn_q_q <= sgn_q_d;
            sgn_r_q <= sgn_r_d;
        end
    end

    assign stall_req  = ~rst & div_op & (state_q != S_DONE);
    assign div_busy   = ~rst & (state_q == S_BUSY);
    assign hilo_rdata = inst_mfhi ? hi_q : (inst_mflo ? lo_q : '0);

endmodule

// File: tb/tb_ex_hilo_div.sv
// Scoreboard bench for ex_hilo_div: queued HI/LO expectations read back via mfhi/mflo.
`ifndef StallBus
`define StallBus 5:0
`endif
`ifndef NoStop
`define NoStop 1'b0
`endif
`ifndef Stop
`define Stop 1'b1
`endif

module tb_ex_hilo_div;

    logic             clk;
    logic             rst;
    logic [`StallBus] stall;
    logic             inst_div, inst_divu, inst_mult, inst_multu;
    logic             inst_mthi, inst_mtlo, inst_mfhi, inst_mflo;
    logic [31:0]      rs_data, rt_data;
    logic [31:0]      hilo_rdata;
    logic             stall_req, div_busy;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [63:0] sb_q[$];

    ex_hilo_div #(.DIV_BITS(32)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .inst_div(inst_div), .inst_divu(inst_divu),
        .inst_mult(inst_mult), .inst_multu(inst_multu),
        .inst_mthi(inst_mthi), .inst_mtlo(inst_mtlo),
        .inst_mfhi(inst_mfhi), .inst_mflo(inst_mflo),
        .rs_data(rs_data), .rt_data(rt_data),
        .hilo_rdata(hilo_rdata), .stall_req(stall_req),
        .div_busy(div_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] div_ref(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input bit sgn);
        longint sa, sb, q, r;
        logic [63:0] qv, rv;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q = sa / sb;
            r = sa % sb;
            qv = q;
            rv = r;
        end else begin
            qv = {32'd0, a / b};
            rv = {32'd0, a % b};
        end
        return {rv[31:0], qv[31:0]};
    endfunction

    task automatic clr_ops();
        inst_div = 0; inst_divu = 0; inst_mult = 0; inst_multu = 0;
        inst_mthi = 0; inst_mtlo = 0; inst_mfhi = 0; inst_mflo = 0;
    endtask

    task automatic read_hilo(input string tag);
        logic [63:0] e;
        if (sb_q.size() == 0) begin
            chk({tag, "_sbempty"}, 32'd0, 32'd1);
            return;
        end
        e = sb_q.pop_front();
        inst_mfhi = 1; #1;
        chk({tag, "_hi"}, hilo_rdata, e[63:32]);
        inst_mfhi = 0; inst_mflo = 1; #1;
        chk({tag, "_lo"}, hilo_rdata, e[31:0]);
        inst_mflo = 0;
        m_hi = e[63:32];
        m_lo = e[31:0];
        @(negedge clk);
    endtask

    task automatic run_div(input string tag, input logic [31:0] a,
                           input logic [31:0] b, input bit sgn,
                           input int hold);
        int cnt;
        int exp_lat;
        logic [31:0] ma, mb;
        ma = (sgn && a[31]) ? -a : a;
        mb = (sgn && b[31]) ? -b : b;
        exp_lat = 33;
        if (b == 0) exp_lat = 1;
`ifdef DIV_EARLY_OUT_EN
        if (b != 0 && ma < mb) exp_lat = 1;
`endif
        sb_q.push_back(div_ref(a, b, sgn));
        stall[3] = (hold > 0) ? `Stop : `NoStop;
        rs_data = a; rt_data = b;
        inst_div = sgn; inst_divu = !sgn;
        #1;
        cnt = 0;
        while (stall_req && cnt < 100) begin
            cnt++;
            @(negedge clk); #1;
        end
        chk({tag, "_lat"}, cnt, exp_lat);
        chk({tag, "_donebusy"}, {31'd0, div_busy}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            chk({tag, "_holdhi"}, dut.hi_q, m_hi);
            chk({tag, "_holdlo"}, dut.lo_q, m_lo);
            chk({tag, "_holdstall"}, {31'd0, stall_req}, 32'd0);
            @(negedge clk); #1;
        end
        stall[3] = `NoStop;
        @(negedge clk);
        clr_ops();
        #1;
        chk({tag, "_idle"}, {31'd0, stall_req | div_busy}, 32'd0);
        read_hilo(tag);
    endtask

    task automatic run_mul(input string tag, input logic [31:0] a,
                           input logic [31:0] b, input bit sgn);
        logic [63:0] p;
        if (sgn) p = longint'($signed(a)) * longint'($signed(b));
        else     p = {32'd0, a} * {32'd0, b};
        sb_q.push_back(p);
        stall[3] = `NoStop;
        rs_data = a; rt_data = b;
        inst_mult = sgn; inst_multu = !sgn;
        #1;
        chk({tag, "_nostall"}, {31'd0, stall_req}, 32'd0);
        @(negedge clk);
        clr_ops();
        read_hilo(tag);
    endtask

    task automatic run_mt(input string tag, input bit to_hi,
                          input logic [31:0] v, input bit adv);
        logic [63:0] e;
        e = {m_hi, m_lo};
        if (adv) begin
            if (to_hi) e[63:32] = v;
            else       e[31:0]  = v;
        end
        sb_q.push_back(e);
        stall[3] = adv ? `NoStop : `Stop;
        rs_data = v;
        inst_mthi = to_hi; inst_mtlo = !to_hi;
        @(negedge clk);
        clr_ops();
        stall[3] = `NoStop;
        read_hilo(tag);
    endtask

    initial begin
        rst = 1; stall = '0;
        clr_ops();
        rs_data = 32'd7; rt_data = 32'd2;
        inst_div = 1;
        @(negedge clk); #1;
        chk("rst_stall", {31'd0, stall_req}, 32'd0);
        chk("rst_busy", {31'd0, div_busy}, 32'd0);
        @(negedge clk);
        clr_ops();
        rst = 0;
        sb_q.push_back(64'd0);
        read_hilo("rst");

        run_div("d7_2", 32'd7, 32'd2, 1, 0);
        run_div("dm7_2", 32'hFFFF_FFF9, 32'd2, 1, 0);
        run_div("du_ff", 32'hFFFF_FFFF, 32'h10, 0, 0);
        run_div("d5_0", 32'd5, 32'd0, 1, 0);
        run_div("d100_7", 32'd100, 32'd7, 1, 3);
        run_div("dmin_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1, 0);
        run_div("d3_9", 32'd3, 32'd9, 1, 0);
        run_div("dm9_4", 32'hFFFF_FFF7, 32'hFFFF_FFFC, 1, 0);
        for (int k = 0; k < 3; k++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom_range(1, 1000);
            run_div("drnd", a, b, k[0], 0);
        end
        run_mul("mul", 32'hFFFF_FFFE, 32'd3, 1);
        run_mul("mulu", 32'hFFFF_FFFE, 32'd3, 0);
        run_mt("mthi_stall", 1, 32'h1234, 0);
        run_mt("mthi", 1, 32'h1234, 1);
        run_mt("mtlo", 0, 32'hCAFE, 1);

        stall[3] = `NoStop;
        rs_data = 32'd7; rt_data = 32'd2;
        inst_div = 1;
        repeat (10) @(negedge clk);
        #1;
        chk("mid_busy", {31'd0, div_busy}, 32'd1);
        rst = 1; #1;
        chk("mid_rst_stall", {31'd0, stall_req}, 32'd0);
        @(negedge clk);
        rst = 0;
        clr_ops();
        #1;
        chk("mid_idle", {31'd0, div_busy | stall_req}, 32'd0);
        sb_q.push_back(64'd0);
        read_hilo("mid");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
